alloc_arbiter: RTL and testbench

- Shares the single SRAM block allocator (linked-list free-space manager) between N requesters, e.g. ingress ports and the dequeue/free path.
- Accepts alloc and free commands per port and selects one at a time by round-robin.
- Issues a one-cycle command to the allocator, waits for completion with a timeout, and returns address and status to the winning port.
- Serialises all allocator access, so the allocator never sees overlapping commands.

---
 rtl/alloc_arbiter.sv | 144 ++++++++++++++
 tb/tb_alloc_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alloc_arbiter.sv
// alloc_arbiter: round-robin arbiter that serialises alloc/free commands from
// N_PORTS requesters onto a single block allocator, with a completion timeout.
//   state | meaning
//   IDLE  | waiting for a request, accepts the round-robin winner
//   ISSUE | one-cycle command strobe to the allocator
//   WAIT  | waiting for mgr_done or timeout
//   RESP  | one-cycle response to the winning port
module alloc_arbiter #(
  parameter int N_PORTS = 4,
  parameter int SIZE_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS-1:0]          req_op,
  input  logic [N_PORTS*SIZE_W-1:0]   req_size,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  output logic [N_PORTS-1:0]          req_ready,
  output logic [N_PORTS-1:0]          rsp_valid,
  output logic [ADDR_W-1:0]           rsp_addr,
  output logic [1:0]                  rsp_status,
  output logic                        mgr_req,
  output logic                        mgr_op,
  output logic [SIZE_W-1:0]           mgr_size,
  output logic [ADDR_W-1:0]           mgr_addr,
  input  logic                        mgr_done,
  input  logic                        mgr_fail,
  input  logic [ADDR_W-1:0]           mgr_rsp_addr,
  output logic                        busy,
  output logic [15:0]                 fail_cnt
);

  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [N_PORTS-1:0] ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        sel;
  logic [CW-1:0]        wcnt;

  logic [N_PORTS-1:0]   rot;
  logic [PW-1:0]        pick;
  logic                 found;
  logic                 accept;
  logic                 pick_op;
  logic [SIZE_W-1:0]    pick_size;
  logic [ADDR_W-1:0]    pick_addr;

  // Rotate valids so bit 0 is the rr_ptr port; the lowest set bit wins.
  always_comb begin
    rot   = N_PORTS'({req_valid, req_valid} >> rr_ptr);
    found = |rot;
    pick  = rr_ptr;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (rot[i]) pick = PW'((int'(rr_ptr) + i) % N_PORTS);
    pick_op   = 1'b0;
    pick_size = '0;
    pick_addr = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (PW'(i) == pick) begin
        pick_op   = req_op[i];
        pick_size = req_size[i*SIZE_W +: SIZE_W];
        pick_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
  end

  assign accept    = rst_n && (state == IDLE) && found;
  assign req_ready = accept ? (ONE << pick) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      sel        <= '0;
      wcnt       <= '0;
      rsp_valid  <= '0;
      rsp_addr   <= '0;
      rsp_status <= 2'b00;
      mgr_req    <= 1'b0;
      mgr_op     <= 1'b0;
      mgr_size   <= '0;
      mgr_addr   <= '0;
      busy       <= 1'b0;
      fail_cnt   <= 16'd0;
    end else begin
      mgr_req    <= 1'b0;
      rsp_valid  <= '0;
      rsp_addr   <= '0;
      rsp_status <= 2'b00;
      case (state)
        IDLE: begin
          if (found) begin
            sel      <= pick;
            mgr_op   <= pick_op;
            mgr_size <= pick_size;
            mgr_addr <= pick_addr;
            busy     <= 1'b1;
            // zero-size alloc is answered locally, allocator untouched
            if (!pick_op && (pick_size == '0)) begin
              state      <= RESP;
              rsp_valid  <= ONE << pick;
              rsp_status <= 2'b11;
            end else begin
              state   <= ISSUE;
              mgr_req <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mgr_done) begin
            state      <= RESP;
            rsp_valid  <= ONE << sel;
            rsp_status <= mgr_fail ? 2'b01 : 2'b00;
            rsp_addr   <= (!mgr_fail && !mgr_op) ? mgr_rsp_addr : '0;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            state      <= RESP;
            rsp_valid  <= ONE << sel;
            rsp_status <= 2'b10;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          if ((rsp_status != 2'b00) && (fail_cnt != 16'hFFFF))
            fail_cnt <= fail_cnt + 16'd1;
          rr_ptr <= (sel == PW'(N_PORTS - 1)) ? '0 : sel + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alloc_arbiter.sv
// Directed testbench for alloc_arbiter: inputs driven and outputs sampled
// on the falling edge; expected values are hand-computed per scenario.
module tb_alloc_arbiter;
  localparam int NP = 4;
  localparam int SW = 8;
  localparam int AW = 12;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_valid, req_op;
  logic [NP*SW-1:0]  req_size;
  logic [NP*AW-1:0]  req_addr;
  logic [NP-1:0]     req_ready, rsp_valid;
  logic [AW-1:0]     rsp_addr;
  logic [1:0]        rsp_status;
  logic              mgr_req, mgr_op;
  logic [SW-1:0]     mgr_size;
  logic [AW-1:0]     mgr_addr;
  logic              mgr_done, mgr_fail;
  logic [AW-1:0]     mgr_rsp_addr;
  logic              busy;
  logic [15:0]       fail_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alloc_arbiter #(.N_PORTS(NP), .SIZE_W(SW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_status(rsp_status),
    .mgr_req(mgr_req), .mgr_op(mgr_op), .mgr_size(mgr_size), .mgr_addr(mgr_addr),
    .mgr_done(mgr_done), .mgr_fail(mgr_fail), .mgr_rsp_addr(mgr_rsp_addr),
    .busy(busy), .fail_cnt(fail_cnt)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic op, input logic [SW-1:0] sz, input logic [AW-1:0] ad);
    req_op[p] = op;
    req_size[p*SW +: SW] = sz;
    req_addr[p*AW +: AW] = ad;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    repeat (2) cyc();
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mgr_req !== 1'b0) begin bad++; $display("FAIL reset_mgr_req: got %b want 0", mgr_req); end
    total++; if (rsp_valid !== 4'b0000 || rsp_status !== 2'b00 || rsp_addr !== 12'h000) begin
      bad++; $display("FAIL reset_rsp: valid %b status %b addr %h want 0/0/0", rsp_valid, rsp_status, rsp_addr); end
    total++; if (fail_cnt !== 16'd0 || mgr_size !== 8'd0 || mgr_addr !== 12'h000 || mgr_op !== 1'b0) begin
      bad++; $display("FAIL reset_regs: fail_cnt %0d size %0d addr %h op %b want all 0", fail_cnt, mgr_size, mgr_addr, mgr_op); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 8'(p + 1), 12'h000);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      #1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp); end
      cyc();
      total++; if (mgr_req !== 1'b1 || mgr_size !== 8'((g % 4) + 1)) begin
        bad++; $display("FAIL rr_issue%0d: mgr_req %b size %0d want 1/%0d", g, mgr_req, mgr_size, (g % 4) + 1); end
      cyc();
      mgr_done = 1'b1; mgr_rsp_addr = 12'(16 * ((g % 4) + 1));
      cyc();
      mgr_done = 1'b0;
      total++; if (rsp_valid !== exp || rsp_addr !== 12'(16 * ((g % 4) + 1)) || rsp_status !== 2'b00) begin
        bad++; $display("FAIL rr_rsp%0d: valid %b addr %h status %b want %b/%h/00", g, rsp_valid, rsp_addr, rsp_status, exp, 12'(16 * ((g % 4) + 1))); end
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_single_alloc();
    set_port(2, 1'b0, 8'd16, 12'h000);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    cyc();
    req_valid = '0;
    total++; if (mgr_req !== 1'b1 || mgr_size !== 8'd16 || mgr_op !== 1'b0) begin
      bad++; $display("FAIL single_issue: req %b size %0d op %b want 1/16/0", mgr_req, mgr_size, mgr_op); end
    cyc();
    total++; if (mgr_req !== 1'b0 || rsp_valid !== 4'b0000 || busy !== 1'b1) begin
      bad++; $display("FAIL single_wait: req %b rsp %b busy %b want 0/0000/1", mgr_req, rsp_valid, busy); end
    cyc();
    mgr_done = 1'b1; mgr_rsp_addr = 12'h040;
    cyc();
    mgr_done = 1'b0; mgr_rsp_addr = 12'h000;
    total++; if (rsp_valid !== 4'b0100 || rsp_addr !== 12'h040 || rsp_status !== 2'b00) begin
      bad++; $display("FAIL single_rsp: valid %b addr %h status %b want 0100/040/00", rsp_valid, rsp_addr, rsp_status); end
    cyc();
    total++; if (rsp_valid !== 4'b0000 || rsp_addr !== 12'h000 || busy !== 1'b0) begin
      bad++; $display("FAIL single_after: valid %b addr %h busy %b want 0/000/0", rsp_valid, rsp_addr, busy); end
  endtask

  task automatic test_free();
    set_port(3, 1'b1, 8'd4, 12'h100);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL free_ready: got %b want 1000", req_ready); end
    cyc();
    req_valid = '0;
    total++; if (mgr_req !== 1'b1 || mgr_op !== 1'b1 || mgr_addr !== 12'h100) begin
      bad++; $display("FAIL free_issue: req %b op %b addr %h want 1/1/100", mgr_req, mgr_op, mgr_addr); end
    cyc();
    mgr_done = 1'b1; mgr_rsp_addr = 12'hABC;
    cyc();
    mgr_done = 1'b0;
    total++; if (rsp_valid !== 4'b1000 || rsp_addr !== 12'h000 || rsp_status !== 2'b00) begin
      bad++; $display("FAIL free_rsp: valid %b addr %h status %b want 1000/000/00", rsp_valid, rsp_addr, rsp_status); end
    cyc();
  endtask

  task automatic test_alloc_fail();
    set_port(0, 1'b0, 8'd5, 12'h000);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL afail_ready: got %b want 0001", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    mgr_done = 1'b1; mgr_fail = 1'b1; mgr_rsp_addr = 12'h123;
    cyc();
    mgr_done = 1'b0; mgr_fail = 1'b0;
    total++; if (rsp_valid !== 4'b0001 || rsp_status !== 2'b01 || rsp_addr !== 12'h000) begin
      bad++; $display("FAIL afail_rsp: valid %b status %b addr %h want 0001/01/000", rsp_valid, rsp_status, rsp_addr); end
    cyc();
    total++; if (fail_cnt !== 16'd1) begin bad++; $display("FAIL afail_cnt: got %0d want 1", fail_cnt); end
  endtask

  task automatic test_zero_size();
    set_port(1, 1'b0, 8'd0, 12'h000);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL zero_ready: got %b want 0010", req_ready); end
    cyc();
    req_valid = '0;
    total++; if (rsp_valid !== 4'b0010 || rsp_status !== 2'b11 || rsp_addr !== 12'h000 || mgr_req !== 1'b0) begin
      bad++; $display("FAIL zero_rsp: valid %b status %b addr %h mgr_req %b want 0010/11/000/0", rsp_valid, rsp_status, rsp_addr, mgr_req); end
    cyc();
    total++; if (mgr_req !== 1'b0 || busy !== 1'b0 || fail_cnt !== 16'd2) begin
      bad++; $display("FAIL zero_after: mgr_req %b busy %b fail_cnt %0d want 0/0/2", mgr_req, busy, fail_cnt); end
  endtask

  task automatic test_timeout();
    int lat;
    logic [1:0] st;
    logic [NP-1:0] rv;
    logic [AW-1:0] ad;
    lat = 0; st = 2'b00; rv = '0; ad = '0;
    set_port(2, 1'b0, 8'd3, 12'h000);
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    total++; if (mgr_req !== 1'b1) begin bad++; $display("FAIL tmo_issue: mgr_req %b want 1", mgr_req); end
    // 64 WAIT cycles follow the strobe; the response lands one cycle later
    for (int k = 1; k <= 70; k++) begin
      cyc();
      if (rsp_valid !== 4'b0000 && lat == 0) begin
        lat = k; st = rsp_status; rv = rsp_valid; ad = rsp_addr;
      end
    end
    total++; if (lat != 65) begin bad++; $display("FAIL tmo_latency: got %0d cycles want 65 after mgr_req", lat); end
    total++; if (st !== 2'b10 || rv !== 4'b0100 || ad !== 12'h000) begin
      bad++; $display("FAIL tmo_rsp: status %b valid %b addr %h want 10/0100/000", st, rv, ad); end
    total++; if (fail_cnt !== 16'd3) begin bad++; $display("FAIL tmo_cnt: got %0d want 3", fail_cnt); end
    mgr_done = 1'b1; mgr_rsp_addr = 12'h0F0;
    cyc();
    mgr_done = 1'b0;
    total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || mgr_req !== 1'b0) begin
      bad++; $display("FAIL late_done: busy %b rsp %b mgr_req %b want 0/0000/0", busy, rsp_valid, mgr_req); end
    cyc();
    total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || fail_cnt !== 16'd3) begin
      bad++; $display("FAIL late_done2: busy %b rsp %b fail_cnt %0d want 0/0000/3", busy, rsp_valid, fail_cnt); end
  endtask

  task automatic test_done_at_timeout();
    set_port(3, 1'b0, 8'd7, 12'h000);
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    total++; if (mgr_req !== 1'b1) begin bad++; $display("FAIL dto_issue: mgr_req %b want 1", mgr_req); end
    repeat (64) cyc();
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL dto_early: rsp_valid %b want 0000", rsp_valid); end
    mgr_done = 1'b1; mgr_rsp_addr = 12'h7F0;
    cyc();
    mgr_done = 1'b0;
    total++; if (rsp_valid !== 4'b1000 || rsp_status !== 2'b00 || rsp_addr !== 12'h7F0) begin
      bad++; $display("FAIL dto_rsp: valid %b status %b addr %h want 1000/00/7f0", rsp_valid, rsp_status, rsp_addr); end
    cyc();
    total++; if (fail_cnt !== 16'd3) begin bad++; $display("FAIL dto_cnt: got %0d want 3", fail_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    set_port(1, 1'b0, 8'd0, 12'h000);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    cyc();
    set_port(3, 1'b0, 8'd9, 12'h000);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rst_pre_ready: got %b want 1000", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    rst_n = 1'b0;
    cyc();
    total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || mgr_req !== 1'b0 || fail_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_mid: busy %b rsp %b mgr_req %b fail_cnt %0d want 0/0000/0/0", busy, rsp_valid, mgr_req, fail_cnt); end
    rst_n = 1'b1;
    mgr_done = 1'b1; mgr_rsp_addr = 12'h555;
    cyc();
    mgr_done = 1'b0;
    total++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_late_done: rsp %b busy %b want 0000/0", rsp_valid, busy); end
    set_port(1, 1'b0, 8'd6, 12'h000);
    set_port(3, 1'b0, 8'd9, 12'h000);
    req_valid = 4'b1010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_rr_ptr: got %b want 0010", req_ready); end
    cyc();
    req_valid = '0;
    total++; if (mgr_req !== 1'b1 || mgr_size !== 8'd6) begin
      bad++; $display("FAIL rst_issue: req %b size %0d want 1/6", mgr_req, mgr_size); end
    cyc();
    mgr_done = 1'b1; mgr_rsp_addr = 12'h200;
    cyc();
    mgr_done = 1'b0;
    total++; if (rsp_valid !== 4'b0010 || rsp_addr !== 12'h200 || rsp_status !== 2'b00) begin
      bad++; $display("FAIL rst_rsp: valid %b addr %h status %b want 0010/200/00", rsp_valid, rsp_addr, rsp_status); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_end_busy: got %b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_size = '0; req_addr = '0;
    mgr_done = 1'b0; mgr_fail = 1'b0; mgr_rsp_addr = '0;
    cyc();
    test_reset();
    test_round_robin();
    test_single_alloc();
    test_free();
    test_alloc_fail();
    test_zero_size();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
